// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: one add/sub-and-shift step per MUL cycle,
// sequenced by an external controller's state bit and step count.

module booth_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mq,
  input  logic             q_m1,
  input  logic [WIDTH:0]   mcand,
  output logic [WIDTH:0]   acc_n,
  output logic [WIDTH-1:0] mq_n,
  output logic             q_m1_n
);
  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case ({mq[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    // Arithmetic right shift of {sum, mq, q_m1}
    acc_n  = {sum[WIDTH], sum[WIDTH:1]};
    mq_n   = {sum[0], mq[WIDTH-1:1]};
    q_m1_n = mq[0];
  end
endmodule

module booth_datapath #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_clear,
  input  logic               state,
  input  logic [CNT_W-1:0]   count,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] result,
  output logic               op_done
);
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  typedef struct packed {
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic             q_m1;
  } booth_st_t;

  booth_st_t      st, st_n;
  logic [WIDTH:0] mcand;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc    (st.acc),
    .mq     (st.mq),
    .q_m1   (st.q_m1),
    .mcand  (mcand),
    .acc_n  (st_n.acc),
    .mq_n   (st_n.mq),
    .q_m1_n (st_n.q_m1)
  );

  // Extra accumulator bit keeps -2^(WIDTH-1) * -2^(WIDTH-1) exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st      <= '0;
      mcand   <= '0;
      result  <= '0;
      op_done <= 1'b0;
    end else if (op_clear) begin
      st      <= '0;
      mcand   <= '0;
      result  <= '0;
      op_done <= 1'b0;
    end else if (!state) begin
      st.acc  <= '0;
      st.mq   <= multiplier;
      st.q_m1 <= 1'b0;
      mcand   <= {multiplicand[WIDTH-1], multiplicand};
      op_done <= 1'b0;
    end else if (count < STEPS) begin
      st <= st_n;
      if (count == LAST) begin
        result  <= {st_n.acc[WIDTH-1:0], st_n.mq};
        op_done <= 1'b1;
      end
    end
  end
endmodule
